// File: rtl/ksa_pkg.sv
// Shared types and sizing for the Kogge-Stone adder slice.
package ksa_pkg;

   localparam int KSA_WIDTH  = 16;
   localparam int KSA_LEVELS = $clog2(KSA_WIDTH);

   // Generate/propagate pair for one bit or one bit-group
   typedef struct packed {
      logic g;
      logic p;
   } pg_t;

endpackage : ksa_pkg

// File: rtl/ksa_top_16b_pg_cell.sv
// Black cell: merges a high group-(G,P) with the adjacent lower group-(G,P).
module ksa_pg_cell
   import ksa_pkg::*;
(
   input  logic g_hi,
   input  logic p_hi,
   input  logic g_lo,
   input  logic p_lo,
   output logic g,
   output logic p
);

   assign g = g_hi | (p_hi & g_lo);
   assign p = p_hi & p_lo;

endmodule : ksa_pg_cell

// File: rtl/ksa_top_16b.sv
// Unsigned Kogge-Stone adder: {c32, s} = a + b + c0, with an optional
// output register stage (REG_OUT=1, one cycle latency, async reset).
module ksa_top_16b
   import ksa_pkg::*;
#(
   parameter int WIDTH   = KSA_WIDTH,
   parameter bit REG_OUT = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             c0,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] s,
   output logic             c32
);

   localparam int LEVELS = $clog2(WIDTH);

   logic [WIDTH-1:0] p_raw;
   logic [WIDTH-1:0] carry;
   logic [WIDTH-1:0] sum_c;
   logic             cout_c;

   assign p_raw = a ^ b;

   // Level 0 holds per-bit (g,p); levels 1..LEVELS are the prefix tree.
   // Each level lives in its own generate scope so no vector depends on
   // other bits of itself.
   for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
      pg_t [WIDTH-1:0] pg;

      if (k == 0) begin : g_pre
         // Bit 0 absorbs c0 as the bit -1 term (G=c0, P=0), so every
         // later group that reaches bit 0 already includes the carry-in.
         ksa_pg_cell u_cin_cell (
            .g_hi (a[0] & b[0]),
            .p_hi (p_raw[0]),
            .g_lo (c0),
            .p_lo (1'b0),
            .g    (pg[0].g),
            .p    (pg[0].p)
         );
         for (genvar i = 1; i < WIDTH; i++) begin : g_bit
            assign pg[i].g = a[i] & b[i];
            assign pg[i].p = p_raw[i];
         end
      end else begin : g_tree
         localparam int D = 1 << (k - 1);
         for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= D) begin : g_black
               ksa_pg_cell u_cell (
                  .g_hi (g_lvl[k-1].pg[i].g),
                  .p_hi (g_lvl[k-1].pg[i].p),
                  .g_lo (g_lvl[k-1].pg[i-D].g),
                  .p_lo (g_lvl[k-1].pg[i-D].p),
                  .g    (pg[i].g),
                  .p    (pg[i].p)
               );
            end else begin : g_pass
               assign pg[i] = g_lvl[k-1].pg[i];
            end
         end
      end
   end

   // Carry into bit i is the group generate of bits [i-1:-1].
   assign carry[0] = c0;
   for (genvar i = 1; i < WIDTH; i++) begin : g_carry
      assign carry[i] = g_lvl[LEVELS].pg[i-1].g;
   end

   assign sum_c  = p_raw ^ carry;
   assign cout_c = g_lvl[LEVELS].pg[WIDTH-1].g;

   if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] s_d;
      logic [WIDTH-1:0] s_q;
      logic             c32_d;
      logic             c32_q;

      // Next register value is simply the fresh combinational result
      always_comb begin
         s_d   = sum_c;
         c32_d = cout_c;
      end

      // Output stage; reset clears any in-flight result immediately
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s_q   <= '0;
            c32_q <= 1'b0;
         end else begin
            s_q   <= s_d;
            c32_q <= c32_d;
         end
      end

      assign s   = s_q;
      assign c32 = c32_q;
   end else begin : g_comb
      // clk/rst_n are intentionally ignored in the combinational build
      logic unused_clk_rst;
      assign unused_clk_rst = ^{clk, rst_n};

      assign s   = sum_c;
      assign c32 = cout_c;
   end

endmodule : ksa_top_16b

// File: tb/tb_ksa_top_16b.sv
// Directed and sweep checks for ksa_top_16b, combinational and registered builds.
module tb_ksa_top_16b;

   logic        clk;
   logic        rst_n;

   logic        c0;
   logic [15:0] a;
   logic [15:0] b;
   logic [15:0] s;
   logic        c32;

   logic        rc0;
   logic [15:0] ra;
   logic [15:0] rb;
   logic [15:0] rs;
   logic        rc32;

   int n_tests;
   int n_fail;
   int num_wrong;

   ksa_top_16b #(.WIDTH(16), .REG_OUT(1'b0)) u_dut_comb (
      .clk   (clk),
      .rst_n (rst_n),
      .c0    (c0),
      .a     (a),
      .b     (b),
      .s     (s),
      .c32   (c32)
   );

   ksa_top_16b #(.WIDTH(16), .REG_OUT(1'b1)) u_dut_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .c0    (rc0),
      .a     (ra),
      .b     (rb),
      .s     (rs),
      .c32   (rc32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic comb_vec(input string tag, input logic [15:0] va, input logic [15:0] vb,
                           input logic vc, input logic [16:0] exp);
      a  = va;
      b  = vb;
      c0 = vc;
      #2;
      check(tag, {c32, s}, exp);
   endtask

   initial begin
      logic [31:0] r;
      logic [16:0] exp_sum;

      n_tests   = 0;
      n_fail    = 0;
      num_wrong = 0;
      rst_n     = 1'b0;
      a = '0; b = '0; c0 = 1'b0;
      ra = '0; rb = '0; rc0 = 1'b0;

      // Combinational build: directed vectors
      comb_vec("zero",        16'h0000, 16'h0000, 1'b0, 17'h00000);
      comb_vec("zero_cin",    16'h0000, 16'h0000, 1'b1, 17'h00001);
      comb_vec("wrap_ripple", 16'hFFFF, 16'h0001, 1'b0, 17'h10000);
      comb_vec("max_result",  16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
      comb_vec("prop_chain",  16'hAAAA, 16'h5555, 1'b1, 17'h10000);
      comb_vec("prop_no_cin", 16'hAAAA, 16'h5555, 1'b0, 17'h0FFFF);
      comb_vec("mid_carry",   16'h00FF, 16'h0001, 1'b0, 17'h00100);
      comb_vec("cin_ripple",  16'h7FFF, 16'h0000, 1'b1, 17'h08000);
      comb_vec("mixed",       16'h1234, 16'h0FFF, 1'b1, 17'h02234);

      // Combinational build: sweep near the top of the range
      for (int ia = 16'hFFFA; ia <= 16'hFFFE; ia++) begin
         for (int ib = 0; ib < 1024; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               a  = 16'(ia);
               b  = 16'(ib);
               c0 = 1'(ic);
               #2;
               exp_sum = 17'(ia) + 17'(ib) + 17'(ic);
               if ({c32, s} !== exp_sum) num_wrong++;
            end
         end
      end

      // Combinational build: random vectors
      for (int n = 0; n < 100000; n++) begin
         r  = $urandom;
         a  = r[15:0];
         b  = r[31:16];
         c0 = 1'($urandom_range(0, 1));
         #2;
         exp_sum = {1'b0, a} + {1'b0, b} + {16'h0000, c0};
         if ({c32, s} !== exp_sum) num_wrong++;
      end
      check("sweep_random_wrong", 17'(num_wrong), 17'd0);

      // Registered build: reset state while rst_n is low
      @(negedge clk);
      ra = 16'h1234; rb = 16'h0FFF; rc0 = 1'b1;
      #1;
      check("reg_reset_state", {rc32, rs}, 17'h00000);

      // Release reset between edges; first result on the next rising edge
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reg_before_first_edge", {rc32, rs}, 17'h00000);
      @(posedge clk);
      #1;
      check("reg_first_result", {rc32, rs}, 17'h02234);

      @(negedge clk);
      ra = 16'hFFFF; rb = 16'h0001; rc0 = 1'b0;
      #1;
      check("reg_holds_between_edges", {rc32, rs}, 17'h02234);
      @(posedge clk);
      #1;
      check("reg_wrap", {rc32, rs}, 17'h10000);

      // Reset mid-cycle: outputs clear at once, in-flight value dropped
      @(negedge clk);
      ra = 16'hFFFF; rb = 16'hFFFF; rc0 = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      check("reg_async_clear", {rc32, rs}, 17'h00000);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reg_held_in_reset", {rc32, rs}, 17'h00000);

      @(negedge clk);
      rst_n = 1'b1;
      ra = 16'h00FF; rb = 16'h0001; rc0 = 1'b0;
      #1;
      check("reg_no_stale_after_release", {rc32, rs}, 17'h00000);
      @(posedge clk);
      #1;
      check("reg_tracks_after_release", {rc32, rs}, 17'h00100);

      @(negedge clk);
      ra = 16'hAAAA; rb = 16'h5555; rc0 = 1'b1;
      @(posedge clk);
      #1;
      check("reg_prop_chain", {rc32, rs}, 17'h10000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_ksa_top_16b
